// File: rtl/detector_jogada.sv
// rtl/detector_jogada.sv - debounced one-hot key play detector
//
// Ports:
//   clock           system clock, rising-edge active
//   reset           synchronous active-low reset
//   limpa           synchronous clear of the stored play
//   chaves[3:0]     raw player keys, one bit per LED position
//   jogada_feita    one-cycle pulse, a valid one-hot play was accepted
//   jogada[3:0]     last accepted play (registered)
//   jogada_invalida one-cycle pulse, a stable multi-key pattern was seen
//   tem_jogada      combinational OR of chaves
//   db_estado[2:0]  current FSM state code

module detector_jogada #(
  parameter int DEBOUNCE_CICLOS = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       limpa,
  input  logic [3:0] chaves,
  output logic       jogada_feita,
  output logic [3:0] jogada,
  output logic       jogada_invalida,
  output logic       tem_jogada,
  output logic [2:0] db_estado
);

  typedef enum logic [2:0] {
    OCIOSO        = 3'd0,
    FILTRA        = 3'd1,
    DETECTADO     = 3'd2,
    ESPERA_SOLTAR = 3'd3,
    LIBERA        = 3'd4
  } estado_t;

  // Terminal count shared by the press filter and the release filter.
  localparam logic [7:0] CNT_MAX = 8'(DEBOUNCE_CICLOS - 1);

  estado_t    estado, estado_next;
  logic [7:0] cnt, cnt_next;
  logic [3:0] amostra, amostra_next;
  logic       carrega_jogada;
  logic       amostra_one_hot;

  assign amostra_one_hot = (amostra != 4'd0) && ((amostra & (amostra - 4'd1)) == 4'd0);

  always_comb begin
    estado_next    = estado;
    cnt_next       = cnt;
    amostra_next   = amostra;
    carrega_jogada = 1'b0;
    case (estado)
      OCIOSO: begin
        if (chaves != 4'd0) begin
          estado_next  = FILTRA;
          amostra_next = chaves;
          cnt_next     = 8'd0;
        end
      end
      FILTRA: begin
        if (chaves == 4'd0) begin
          estado_next = OCIOSO;
        end else if (chaves != amostra) begin
          // Pattern still moving: restart the stability window on the new value.
          amostra_next = chaves;
          cnt_next     = 8'd0;
        end else if (cnt == CNT_MAX) begin
          estado_next    = DETECTADO;
          carrega_jogada = amostra_one_hot;
        end else begin
          cnt_next = cnt + 8'd1;
        end
      end
      DETECTADO: begin
        estado_next = ESPERA_SOLTAR;
      end
      ESPERA_SOLTAR: begin
        if (chaves == 4'd0) begin
          estado_next = LIBERA;
          cnt_next    = 8'd0;
        end
      end
      LIBERA: begin
        // Any key during the release window means the release was a bounce.
        if (chaves != 4'd0) begin
          estado_next = ESPERA_SOLTAR;
        end else if (cnt == CNT_MAX) begin
          estado_next = OCIOSO;
        end else begin
          cnt_next = cnt + 8'd1;
        end
      end
      default: begin
        estado_next = OCIOSO;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      estado  <= OCIOSO;
      cnt     <= 8'd0;
      amostra <= 4'd0;
      jogada  <= 4'd0;
    end else if (limpa) begin
      // Parking in LIBERA makes the current press wait for a full release,
      // so it can never produce a pulse after being cleared.
      estado <= LIBERA;
      cnt    <= 8'd0;
      jogada <= 4'd0;
    end else begin
      estado  <= estado_next;
      cnt     <= cnt_next;
      amostra <= amostra_next;
      if (carrega_jogada) begin
        jogada <= amostra;
      end
    end
  end

  assign jogada_feita    = (estado == DETECTADO) && amostra_one_hot;
  assign jogada_invalida = (estado == DETECTADO) && !amostra_one_hot;
  assign tem_jogada      = |chaves;
  assign db_estado       = estado;

endmodule

// File: tb/tb_detector_jogada.sv
// tb/tb_detector_jogada.sv - table-driven bench for detector_jogada

module tb_detector_jogada;

  logic       clock;
  logic       reset;
  logic       limpa;
  logic [3:0] chaves;
  logic       jogada_feita;
  logic [3:0] jogada;
  logic       jogada_invalida;
  logic       tem_jogada;
  logic [2:0] db_estado;

  int compared;
  int mismatched;

  detector_jogada #(.DEBOUNCE_CICLOS(3)) dut (
    .clock          (clock),
    .reset          (reset),
    .limpa          (limpa),
    .chaves         (chaves),
    .jogada_feita   (jogada_feita),
    .jogada         (jogada),
    .jogada_invalida(jogada_invalida),
    .tem_jogada     (tem_jogada),
    .db_estado      (db_estado)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic       rst;
    logic       lmp;
    logic [3:0] ch;
    logic [2:0] st;
    logic       f;
    logic       inv;
    logic [3:0] j;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input int rst, input int lmp, input int ch, input int st,
                     input int f, input int inv, input int j);
    vec_t v;
    v.rst = 1'(rst);
    v.lmp = 1'(lmp);
    v.ch  = 4'(ch);
    v.st  = 3'(st);
    v.f   = 1'(f);
    v.inv = 1'(inv);
    v.j   = 4'(j);
    vecs.push_back(v);
  endtask

  task automatic addn(input int n, input int rst, input int lmp, input int ch, input int st,
                      input int f, input int inv, input int j);
    for (int k = 0; k < n; k++) add(rst, lmp, ch, st, f, inv, j);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int n;
    int extra;
    logic [3:0] pat;
    compared   = 0;
    mismatched = 0;
    reset  = 1'b0;
    limpa  = 1'b0;
    chaves = 4'd0;

    // rst, limpa, chaves -> state, feita, invalida, jogada after the edge
    add(0, 0, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0);
    // single key held 10 cycles, then released
    addn(3, 1, 0, 4'b0001, 1, 0, 0, 0);
    add(1, 0, 4'b0001, 2, 1, 0, 1);
    addn(6, 1, 0, 4'b0001, 3, 0, 0, 1);
    addn(3, 1, 0, 0, 4, 0, 0, 1);
    addn(2, 1, 0, 0, 0, 0, 0, 1);
    // 2-cycle glitch
    addn(2, 1, 0, 4'b0010, 1, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 1);
    // two keys held: invalid pulse, play kept
    addn(3, 1, 0, 4'b0101, 1, 0, 0, 1);
    add(1, 0, 4'b0101, 2, 0, 1, 1);
    addn(6, 1, 0, 4'b0101, 3, 0, 0, 1);
    addn(3, 1, 0, 0, 4, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 1);
    // key change while held
    addn(3, 1, 0, 4'b0100, 1, 0, 0, 1);
    add(1, 0, 4'b0100, 2, 1, 0, 4);
    add(1, 0, 4'b0100, 3, 0, 0, 4);
    addn(3, 1, 0, 4'b1000, 3, 0, 0, 4);
    addn(3, 1, 0, 0, 4, 0, 0, 4);
    add(1, 0, 0, 0, 0, 0, 4);
    // limpa on the edge that would enter DETECTADO
    addn(3, 1, 0, 4'b1000, 1, 0, 0, 4);
    add(1, 1, 4'b1000, 4, 0, 0, 0);
    addn(2, 1, 0, 4'b1000, 3, 0, 0, 0);
    addn(3, 1, 0, 0, 4, 0, 0, 0);
    add(1, 0, 0, 0, 0, 0, 0);
    // release bounce
    addn(3, 1, 0, 4'b0001, 1, 0, 0, 0);
    add(1, 0, 4'b0001, 2, 1, 0, 1);
    add(1, 0, 4'b0001, 3, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      add(1, 0, 4'b0001, 3, 0, 0, 1);
      add(1, 0, 0, 4, 0, 0, 1);
    end
    addn(2, 1, 0, 0, 4, 0, 0, 1);
    add(1, 0, 0, 0, 0, 0, 1);
    // reset overrides limpa and inputs
    add(0, 1, 4'b0010, 0, 0, 0, 0);
    // reset mid-filter discards the press; key still down is a new press
    addn(2, 1, 0, 4'b0010, 1, 0, 0, 0);
    add(0, 0, 4'b0010, 0, 0, 0, 0);
    addn(3, 1, 0, 4'b0010, 1, 0, 0, 0);
    add(1, 0, 4'b0010, 2, 1, 0, 2);
    add(1, 0, 4'b0010, 3, 0, 0, 2);
    addn(3, 1, 0, 0, 4, 0, 0, 2);
    add(1, 0, 0, 0, 0, 0, 2);

    #2;
    for (int i = 0; i < vecs.size(); i++) begin
      reset  = vecs[i].rst;
      limpa  = vecs[i].lmp;
      chaves = vecs[i].ch;
      tick();
      chk($sformatf("vec%0d db_estado", i), 8'(db_estado), 8'(vecs[i].st));
      chk($sformatf("vec%0d jogada_feita", i), 8'(jogada_feita), 8'(vecs[i].f));
      chk($sformatf("vec%0d jogada_invalida", i), 8'(jogada_invalida), 8'(vecs[i].inv));
      chk($sformatf("vec%0d jogada", i), 8'(jogada), 8'(vecs[i].j));
      chk($sformatf("vec%0d tem_jogada", i), 8'(tem_jogada), 8'(|vecs[i].ch));
    end

    // tem_jogada is combinational, even while reset is held
    reset = 1'b0;
    for (int p = 0; p < 16; p++) begin
      pat = 4'(p);
      chaves = pat;
      #1;
      chk($sformatf("tem_jogada pat%0d", p), 8'(tem_jogada), 8'(p != 0));
    end
    chaves = 4'd0;
    tick();
    reset = 1'b1;
    tick();

    // bounded wait for acceptance latency, then one pulse for a long hold
    chaves = 4'b1000;
    n = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (jogada_feita) begin
        n = c;
        break;
      end
    end
    chk("latency edges", 8'(n), 8'd4);
    chk("latency jogada", 8'(jogada), 8'b1000);
    extra = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (jogada_feita || jogada_invalida) extra++;
    end
    chk("long hold extra pulses", 8'(extra), 8'd0);

    // reset mid-hold, key still down afterwards is a fresh press
    reset = 1'b0;
    tick();
    chk("reset mid-hold jogada", 8'(jogada), 8'd0);
    reset = 1'b1;
    n = 0;
    for (int c = 1; c <= 20; c++) begin
      tick();
      if (jogada_feita) begin
        n = c;
        break;
      end
    end
    chk("repress latency edges", 8'(n), 8'd4);

    // limpa while waiting for release goes to LIBERA, then back on held key
    limpa = 1'b1;
    tick();
    limpa = 1'b0;
    chk("limpa in hold db_estado", 8'(db_estado), 8'd4);
    chk("limpa in hold jogada", 8'(jogada), 8'd0);
    tick();
    chk("limpa in hold back", 8'(db_estado), 8'd3);
    chaves = 4'd0;
    for (int c = 0; c < 4; c++) tick();
    chk("final idle", 8'(db_estado), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
